// File: rtl/seg_scan_mux.sv
// Seven-segment scan multiplexer: refresh prescaler, digit index, double-buffered
// digit data, dead-time anti-ghosting and optional leading-zero blanking.
module seg_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000,
    parameter bit ACTIVE_LOW  = 1'b1,
    localparam int IW = $clog2(DIGITS),
    localparam int PW = $clog2(REFRESH_DIV)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   BCD,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [IW-1:0]         countout,
    output logic [3:0]            LED_BCD,
    output logic [DIGITS-1:0]     digits,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]     DEAD_END   = PW'(DEAD_CYCLES);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF    = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF    = {DIGITS{ACTIVE_LOW}};

    typedef enum logic {SLOT_DEAD, SLOT_ON} slot_t;

    slot_t                r_state;
    logic [PW-1:0]        r_presc;
    logic [IW-1:0]        r_index;
    logic [4*DIGITS-1:0]  r_staging;
    logic [DIGITS-1:0]    r_stagingDp;
    logic [4*DIGITS-1:0]  r_shadow;
    logic [DIGITS-1:0]    r_shadowDp;
    logic                 r_pending;
    logic                 r_frameWrap;

    logic                 w_terminal;
    logic                 w_boundary;
    logic [PW-1:0]        w_prescNext;
    logic [3:0]           w_nibble;
    logic                 w_dpBit;
    logic [DIGITS-1:0]    w_blankMask;
    logic                 w_run;
    logic [6:0]           w_segOn;
    logic                 w_lit;
    logic [DIGITS-1:0]    w_onehot;

    assign w_terminal  = (r_presc == PRESC_LAST);
    assign w_boundary  = enable && w_terminal && (r_index == IDX_LAST);
    assign w_prescNext = r_presc + 1'b1;
    assign w_nibble    = r_shadow[4*r_index +: 4];
    assign w_dpBit     = r_shadowDp[r_index];
    assign w_onehot    = {{(DIGITS-1){1'b0}}, 1'b1} << r_index;
    assign w_lit       = enable && (r_state == SLOT_ON) && !(blank_lz && w_blankMask[r_index]);

    // A digit is blankable while every digit from the top down to it is zero with no dp.
    always_comb begin
        w_blankMask = '0;
        w_run       = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_run          = w_run && (r_shadow[4*i +: 4] == 4'd0) && !r_shadowDp[i];
            w_blankMask[i] = w_run;
        end
    end

    always_comb begin
        case (w_nibble)
            4'h0:    w_segOn = 7'b0111111;
            4'h1:    w_segOn = 7'b0000110;
            4'h2:    w_segOn = 7'b1011011;
            4'h3:    w_segOn = 7'b1001111;
            4'h4:    w_segOn = 7'b1100110;
            4'h5:    w_segOn = 7'b1101101;
            4'h6:    w_segOn = 7'b1111101;
            4'h7:    w_segOn = 7'b0000111;
            4'h8:    w_segOn = 7'b1111111;
            4'h9:    w_segOn = 7'b1101111;
            4'hA:    w_segOn = 7'b1110111;
            4'hB:    w_segOn = 7'b1111100;
            4'hC:    w_segOn = 7'b0111001;
            4'hD:    w_segOn = 7'b1011110;
            4'hE:    w_segOn = 7'b1111001;
            default: w_segOn = 7'b1110001;
        endcase
    end

    // Slot timing, double buffering and registered display outputs; outputs lag state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SLOT_DEAD;
            r_presc     <= '0;
            r_index     <= '0;
            r_staging   <= '0;
            r_stagingDp <= '0;
            r_shadow    <= '0;
            r_shadowDp  <= '0;
            r_pending   <= 1'b0;
            r_frameWrap <= 1'b0;
            countout    <= '0;
            LED_BCD     <= 4'd0;
            digits      <= DIG_OFF;
            seg         <= SEG_OFF;
            dp          <= ACTIVE_LOW;
            frame_done  <= 1'b0;
        end else begin
            if (!enable) begin
                r_presc <= '0;
                r_state <= SLOT_DEAD;
            end else if (w_terminal) begin
                r_presc <= '0;
                r_index <= (r_index == IDX_LAST) ? '0 : r_index + 1'b1;
                r_state <= SLOT_DEAD;
            end else begin
                r_presc <= w_prescNext;
                if (w_prescNext == DEAD_END) begin
                    r_state <= SLOT_ON;
                end
            end
            r_frameWrap <= w_boundary;

            if (load) begin
                r_staging   <= BCD;
                r_stagingDp <= dp_in;
            end
            // A load landing on the boundary bypasses staging so nothing is left pending.
            if (w_boundary && load) begin
                r_shadow   <= BCD;
                r_shadowDp <= dp_in;
                r_pending  <= 1'b0;
            end else if (w_boundary && r_pending) begin
                r_shadow   <= r_staging;
                r_shadowDp <= r_stagingDp;
                r_pending  <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end

            countout   <= r_index;
            LED_BCD    <= w_nibble;
            frame_done <= r_frameWrap && enable;
            digits     <= (w_lit ? w_onehot : '0) ^ DIG_OFF;
            seg        <= (w_lit ? w_segOn : 7'd0) ^ SEG_OFF;
            dp         <= (w_lit && w_dpBit) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised seven-segment scan multiplexer for the frequency counter display path. It takes a packed BCD/hex word of DIGITS nibbles and owns the refresh prescaler and digit-select counter. It double-buffers the input so a frame never tears, and drives anodes, segments and decimal point with anti-ghosting dead time and optional leading-zero blanking.

## Interface
- DIGITS, 4, number of display digits (2..8)
- REFRESH_DIV, 100000, clk cycles per digit slot (≥ DEAD_CYCLES+2)
- DEAD_CYCLES, 1000, cycles at slot start with all anodes off (≥1)
- ACTIVE_LOW, 1, 1 = anodes/segments/dp active-low, 0 = active-high
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  1 = scanning, 0 = display dark
- BCD  in  4*DIGITS  nibble i = digit i (nibble 0 = rightmost)
- dp_in  in  DIGITS  decimal point request per digit
- load  in  1  one-cycle strobe: capture BCD, dp_in into staging
- blank_lz  in  1  enable leading-zero blanking
- countout  out  clog2(DIGITS)  current digit index
- LED_BCD  out  4  nibble of current digit
- digits  out  DIGITS  anode enables, one-hot when lit
- seg  out  7  {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- frame_done  out  1  one-cycle pulse at frame wrap

## Operation
- Registers:
  - prescaler 0..REFRESH_DIV-1
  - index 0..DIGITS-1
  - staging and shadow copies of {BCD, dp_in}
  - per-slot state DEAD/ON
- load=1: staging ← {BCD, dp_in}. A pending flag is set.
- Frame boundary is prescaler terminal with index=DIGITS-1. At the boundary, if pending, shadow ← staging and pending clears.
  - If load coincides with the boundary, the BCD/dp_in presented that cycle go straight to shadow and pending ends clear.
- Display data always comes from shadow, never from BCD directly.
- Slot FSM:
  - DEAD for prescaler 0..DEAD_CYCLES-1: anodes off, seg off, dp off.
  - ON for the remainder: digits[index] asserted, seg = decode(shadow nibble index), dp = shadow dp[index].
- At prescaler terminal: prescaler → 0 and index → index+1, wrapping DIGITS-1 → 0; FSM → DEAD.
- Decode is hex: 0–9 standard, 10–15 show A b C d E F. Active-low examples: 0 = 1000000, 1 = 1111001, 8 = 0000000, F = 0001110. ACTIVE_LOW=0 inverts seg, digits and dp.
- Leading-zero blanking (blank_lz=1): digit i>0 is blanked if shadow nibbles DIGITS-1..i are all zero and no dp in DIGITS-1..i is set. Digit 0 is never blanked.
  - A blanked digit's slot behaves as DEAD for its full length, but timing and countout still advance.
- enable=0:
  - prescaler forced to 0 and index held
  - all display outputs off and frame_done 0
  - load and staging still operate
  - On enable rising, the slot restarts at DEAD.
- countout and LED_BCD track index and its shadow nibble in every state, including DEAD, disabled and blanked.

## Timing
- All outputs are registered and reflect state one cycle after the internal change. Decode is combinational from shadow/index into the output registers.
- Reset:
  - prescaler=0, index=0, staging=shadow=0, pending=0, FSM=DEAD
  - countout=0, LED_BCD=0, frame_done=0
  - digits, seg and dp all off (all ones when ACTIVE_LOW=1)
- Reset mid-frame: takes effect on the next edge and discards staged data.
- Slot length is exactly REFRESH_DIV cycles. Frame length is DIGITS*REFRESH_DIV. ON length is REFRESH_DIV−DEAD_CYCLES.
- Anode changes are never adjacent: between two lit anodes there are always ≥ DEAD_CYCLES dark cycles.
- frame_done is high for exactly one cycle, the cycle after the boundary, coincident with countout returning to 0.
- Load latency to display: the new value is visible from the first slot after the next frame boundary.

## Test plan
- DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, ACTIVE_LOW=1, BCD=16'h1234, load pulse, enable=1.
  - After the first boundary: countout cycles 0,1,2,3.
  - LED_BCD follows 4,3,2,1.
  - digits = 1110,1101,1011,0111 for 6 cycles each, with 1111 for 2 cycles between.
  - seg for 4 = 0011001.
- Tear-free load: load 16'h5678 mid-slot 1, then load 16'h9ABC in slot 2.
  - Display continues 1234 until the boundary, then shows 9ABC.
  - 5678 never appears. A → seg 0001000.
- Leading-zero blanking: BCD=16'h0007, blank_lz=1 → digits 3..1 stay 1111 and only digit 0 lights with seg 1111000.
  - With dp_in=4'b0100, digits 2..0 light.
  - With BCD=0, digit 0 shows 0.
- Load on boundary: assert load exactly on the boundary cycle → shadow takes that cycle's BCD, pending stays 0, and the next frame shows it.
- enable=0 for 20 cycles mid-slot 2 → all outputs off and countout held at 2.
  - On re-enable: 2 dark cycles, then 6 lit cycles of digit 2.
- reset asserted during an ON cycle → next cycle digits=1111, seg=1111111, countout=0, frame_done=0, and shadow is cleared (displays 0).
